// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte
// producers. One byte is taken per grant. The transmitter is then launched, and
// the block waits for its done strobe. A watchdog aborts the wait if the
// transmitter never answers. All outputs are registered.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef CLKS_PER_BIT
`define CLKS_PER_BIT 1085
`endif

module uart_tx_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = `DATA_WIDTH,
   parameter int TIMEOUT_CYC = 12*`CLKS_PER_BIT
) (
   input  logic                            sysclk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              i_req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_byte,
   output logic [NUM_REQ-1:0]              o_grant,
   output logic [$clog2(NUM_REQ)-1:0]      o_owner,
   output logic                            o_busy,
   output logic                            o_err,
   output logic                            o_tx_start,
   output logic [DATA_WIDTH-1:0]           o_tx_byte,
   input  logic                            i_tx_busy,
   input  logic                            i_tx_done
);

   localparam int              PW        = $clog2(NUM_REQ);
   localparam int              CW        = $clog2(TIMEOUT_CYC+1);
   localparam int unsigned     NREQ_U    = unsigned'(NUM_REQ);
   localparam logic [PW-1:0]   LAST_IDX  = PW'(NUM_REQ-1);
   localparam logic [CW-1:0]   WD_LIMIT  = CW'(TIMEOUT_CYC);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_GAP
   } state_t;

   state_t                 r_state;
   state_t                 w_next_state;
   logic [PW-1:0]          r_ptr;
   logic [CW-1:0]          r_wd;

   logic                   w_found;
   logic [PW-1:0]          w_pick;
   logic [NUM_REQ-1:0]     w_pick_onehot;
   logic [DATA_WIDTH-1:0]  w_pick_byte;
   logic                   w_grant_go;
   logic                   w_start_go;
   logic                   w_err_go;
   logic                   w_wd_clr;

   // Round-robin search: first set request starting at r_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      int unsigned v_idx;
      v_idx         = 0;
      w_found       = 1'b0;
      w_pick        = '0;
      w_pick_onehot = '0;
      for (int unsigned i = 0; i < NREQ_U; i++) begin
         v_idx = 32'(r_ptr) + i;
         if (v_idx >= NREQ_U) begin
            v_idx = v_idx - NREQ_U;
         end
         if (!w_found && i_req[PW'(v_idx)]) begin
            w_found = 1'b1;
            w_pick  = PW'(v_idx);
         end
      end
      w_pick_onehot[w_pick] = 1'b1;
      w_pick_byte           = i_req_byte[32'(w_pick)*DATA_WIDTH +: DATA_WIDTH];
   end

   // State register.
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and per-cycle action decode.
   // A done strobe is tested before the watchdog, so a done strobe and a
   // timeout in the same cycle count as a normal completion.
   always_comb begin
      w_next_state = r_state;
      w_grant_go   = 1'b0;
      w_start_go   = 1'b0;
      w_err_go     = 1'b0;
      w_wd_clr     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_found && !i_tx_busy) begin
               w_grant_go   = 1'b1;
               w_next_state = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            w_start_go   = 1'b1;
            w_wd_clr     = 1'b1;
            w_next_state = S_WAIT;
         end
         S_WAIT: begin
            if (i_tx_done) begin
               w_next_state = S_GAP;
            end else if (r_wd == WD_LIMIT) begin
               w_err_go     = 1'b1;
               w_next_state = S_GAP;
            end
         end
         S_GAP: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Watchdog: cleared on launch, counts while waiting, and saturates at the limit.
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         r_wd <= '0;
      end else if (w_wd_clr) begin
         r_wd <= '0;
      end else if (r_state == S_WAIT && r_wd != WD_LIMIT) begin
         r_wd <= r_wd + 1'b1;
      end
   end

   // Registered outputs, priority pointer and latched byte.
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         o_grant    <= '0;
         o_owner    <= '0;
         o_busy     <= 1'b0;
         o_err      <= 1'b0;
         o_tx_start <= 1'b0;
         o_tx_byte  <= '0;
         r_ptr      <= '0;
      end else begin
         o_grant    <= w_grant_go ? w_pick_onehot : '0;
         o_tx_start <= w_start_go;
         o_err      <= w_err_go;
         o_busy     <= (w_next_state != S_IDLE);
         if (w_grant_go) begin
            o_owner   <= w_pick;
            o_tx_byte <= w_pick_byte;
            r_ptr     <= (w_pick == LAST_IDX) ? '0 : w_pick + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural uart_tx stand-in.
module tb_uart_tx_arbiter;
   localparam int NR    = 4;
   localparam int DW    = 8;
   localparam int TO    = 20;
   localparam int FRAME = 6;

   logic              sysclk = 1'b0;
   logic              rst    = 1'b1;
   logic [NR-1:0]     i_req  = '0;
   logic [NR*DW-1:0]  i_req_byte = '0;
   logic [NR-1:0]     o_grant;
   logic [1:0]        o_owner;
   logic              o_busy, o_err, o_tx_start;
   logic [DW-1:0]     o_tx_byte;
   logic              i_tx_busy, i_tx_done;

   logic              stub_busy, stub_done;
   int                stub_cnt;
   logic              ext_busy = 1'b0;
   logic              ext_done = 1'b0;
   logic              tx_auto  = 1'b1;

   assign i_tx_busy = stub_busy | ext_busy;
   assign i_tx_done = stub_done | ext_done;

   uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT_CYC(TO)) dut (
      .sysclk     (sysclk),
      .rst        (rst),
      .i_req      (i_req),
      .i_req_byte (i_req_byte),
      .o_grant    (o_grant),
      .o_owner    (o_owner),
      .o_busy     (o_busy),
      .o_err      (o_err),
      .o_tx_start (o_tx_start),
      .o_tx_byte  (o_tx_byte),
      .i_tx_busy  (i_tx_busy),
      .i_tx_done  (i_tx_done)
   );

   always #4 sysclk = ~sysclk;

   // Transmitter stand-in: busy for FRAME cycles after a start, then a 1-cycle done.
   always @(posedge sysclk or posedge rst) begin
      if (rst) begin
         stub_busy <= 1'b0;
         stub_done <= 1'b0;
         stub_cnt  <= 0;
      end else begin
         stub_done <= 1'b0;
         if (o_tx_start && tx_auto) begin
            stub_busy <= 1'b1;
            stub_cnt  <= FRAME;
         end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) begin
               stub_busy <= 1'b0;
               stub_done <= 1'b1;
            end
         end
      end
   end

   typedef enum int {EV_GRANT, EV_START, EV_ERR} ev_t;
   typedef struct {
      ev_t           kind;
      logic [NR-1:0] grant;
      logic [1:0]    owner;
      logic [DW-1:0] data;
   } exp_t;

   exp_t expq[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   cyc = 0;
   int   last_grant_cyc = 0;
   int   last_start_cyc = 0;

   always @(posedge sysclk) cyc <= cyc + 1;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic bit pop_expect(input ev_t k, output exp_t e);
      e = '{EV_GRANT, '0, '0, '0};
      if (expq.size() == 0) begin
         compared++;
         mismatched++;
         $display("FAIL unexpected_event: got event %0d expected none (t=%0t)", k, $time);
         return 1'b0;
      end
      e = expq.pop_front();
      check("event_kind", 64'(k), 64'(e.kind));
      return 1'b1;
   endfunction

   task automatic push_tx(input int k, input logic [DW-1:0] d);
      expq.push_back('{EV_GRANT, NR'(1 << k), 2'(k), d});
      expq.push_back('{EV_START, '0, '0, d});
   endtask

   // Monitor: pops one expectation per observed grant/start/err pulse.
   always @(negedge sysclk) begin
      exp_t e;
      if (!rst) begin
         if (o_grant != '0) begin
            if (pop_expect(EV_GRANT, e)) begin
               check("grant", 64'(o_grant), 64'(e.grant));
               check("owner", 64'(o_owner), 64'(e.owner));
               check("grant_byte", 64'(o_tx_byte), 64'(e.data));
            end
            last_grant_cyc = cyc;
         end
         if (o_tx_start) begin
            if (pop_expect(EV_START, e)) begin
               check("start_byte", 64'(o_tx_byte), 64'(e.data));
               check("start_latency", 64'(cyc - last_grant_cyc), 64'(1));
            end
            last_start_cyc = cyc;
         end
         if (o_err) begin
            if (pop_expect(EV_ERR, e)) begin
               check("err_delay", 64'(cyc - last_start_cyc), 64'(TO + 1));
            end
         end
      end
   end

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   task automatic wait_grants(input int n, input string name);
      int got = 0;
      for (int c = 0; c < 300 && got < n; c++) begin
         tick();
         if (o_grant != '0) got++;
      end
      if (got < n) begin
         compared++;
         mismatched++;
         $display("FAIL %s_timeout: got %0d grants expected %0d", name, got, n);
      end
   endtask

   task automatic wait_idle(input string name);
      int c = 0;
      while (o_busy && c < 200) begin
         tick();
         c++;
      end
      check({name, "_idle"}, 64'(o_busy), 64'(0));
   endtask

   task automatic check_zero(input string name);
      check({name, "_grant"}, 64'(o_grant), 64'(0));
      check({name, "_owner"}, 64'(o_owner), 64'(0));
      check({name, "_busy"},  64'(o_busy), 64'(0));
      check({name, "_err"},   64'(o_err), 64'(0));
      check({name, "_start"}, 64'(o_tx_start), 64'(0));
      check({name, "_byte"},  64'(o_tx_byte), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int c;
      // T1 reset
      rst = 1'b1;
      repeat (5) @(posedge sysclk);
      #1;
      check_zero("rst_held");
      rst = 1'b0;
      repeat (10) tick();
      check_zero("rst_idle");

      // T3 fairness from pointer 0
      for (int k = 0; k < NR; k++) i_req_byte[k*DW +: DW] = 8'(8'h10 + k);
      push_tx(0, 8'h10); push_tx(1, 8'h11); push_tx(2, 8'h12);
      push_tx(3, 8'h13); push_tx(0, 8'h10);
      i_req = 4'b1111;
      wait_grants(5, "fair");
      i_req = '0;
      wait_idle("fair");

      // T2 single byte (pointer now 1)
      i_req_byte[2*DW +: DW] = 8'hCB;
      push_tx(2, 8'hCB);
      i_req = 4'b0100;
      wait_grants(1, "single");
      i_req = '0;
      wait_idle("single");

      // T4 pointer wrap (pointer now 3)
      i_req_byte[0*DW +: DW] = 8'hA0;
      i_req_byte[3*DW +: DW] = 8'hB3;
      push_tx(3, 8'hB3); push_tx(0, 8'hA0); push_tx(3, 8'hB3);
      i_req = 4'b1000;
      wait_grants(1, "wrap_a");
      i_req = 4'b1001;
      wait_grants(2, "wrap_b");
      i_req = '0;
      wait_idle("wrap");

      // Transmitter busy blocks grants; withdrawn request leaves no trace
      ext_busy = 1'b1;
      i_req_byte[1*DW +: DW] = 8'h77;
      i_req = 4'b0010;
      repeat (8) tick();
      check("busy_block_busy", 64'(o_busy), 64'(0));
      check("busy_block_grant", 64'(o_grant), 64'(0));
      i_req = '0;
      tick();
      ext_busy = 1'b0;
      repeat (5) tick();
      check("withdraw_busy", 64'(o_busy), 64'(0));

      // Done strobe while idle is ignored
      ext_done = 1'b1;
      tick();
      ext_done = 1'b0;
      repeat (3) tick();
      check("stray_done_busy", 64'(o_busy), 64'(0));
      check("stray_done_err", 64'(o_err), 64'(0));

      // T5 watchdog (pointer 0; only req 1 asks)
      tx_auto = 1'b0;
      i_req_byte[1*DW +: DW] = 8'h5A;
      push_tx(1, 8'h5A);
      expq.push_back('{EV_ERR, '0, '0, '0});
      i_req = 4'b0010;
      wait_grants(1, "wdog");
      i_req = '0;
      c = 0;
      while (!o_err && c < 100) begin
         tick();
         c++;
      end
      check("wdog_err_seen", 64'(o_err), 64'(1));
      check("wdog_busy_at_err", 64'(o_busy), 64'(1));
      tick();
      check("wdog_err_pulse", 64'(o_err), 64'(0));
      check("wdog_busy_after", 64'(o_busy), 64'(0));
      tx_auto = 1'b1;
      repeat (3) tick();

      // T6 reset in WAIT (pointer 2 before, 0 after reset)
      i_req_byte[2*DW +: DW] = 8'hE2;
      push_tx(2, 8'hE2);
      i_req = 4'b0100;
      wait_grants(1, "rst_wait");
      i_req = '0;
      tick();
      tick();
      #2;
      rst = 1'b1;
      #1;
      check_zero("rst_mid");
      tick();
      tick();
      rst = 1'b0;
      for (int k = 0; k < NR; k++) i_req_byte[k*DW +: DW] = 8'(8'hC0 + k);
      push_tx(0, 8'hC0);
      i_req = 4'b1111;
      wait_grants(1, "post_rst");
      i_req = '0;
      wait_idle("post_rst");

      repeat (5) tick();
      check("queue_empty", 64'(expq.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
